// File: rtl/pattern_game_ctrl_pkg.sv
// Shared types and constants for the pattern-memory game controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXTEND   = 3'd1,
        PLAY     = 3'd2,
        COLLECT  = 3'd3,
        ROUND_OK = 3'd4,
        FAIL     = 3'd5,
        WIN      = 3'd6
    } state_e;

    typedef enum logic {
        MODE_CLASSIC = 1'b0,
        MODE_REVERSE = 1'b1
    } mode_e;

    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // One LFSR step: shift left, feed back the XOR of the tapped bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[30:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pattern_game_ctrl_if.sv
// Front-end / display bundle of the game controller.
// master = controller side, slave = input front end and display driver.
interface pattern_game_ctrl_if #(
    parameter int SYM_W = 2,
    parameter int LEN_W = 6
);
    logic             start;
    logic             mode;
    logic [31:0]      seed;
    logic             play_valid;
    logic [SYM_W-1:0] play_sym;
    logic             play_ready;
    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic             in_ready;
    logic [LEN_W-1:0] score;
    logic             busy;
    logic             game_over;
    logic             win;

    modport master (
        input  start, mode, seed, play_ready, in_valid, in_sym,
        output play_valid, play_sym, in_ready, score, busy, game_over, win
    );

    modport slave (
        output start, mode, seed, play_ready, in_valid, in_sym,
        input  play_valid, play_sym, in_ready, score, busy, game_over, win
    );
endinterface

// File: rtl/pattern_game_ctrl_lfsr.sv
// 32-bit pattern LFSR with seed load and single-step enable.
// A zero seed would lock the register, so it is replaced by the default seed.
module pattern_lfsr
    import game_pkg::*;
#(
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      seed,
    output logic [OUT_W-1:0] sym
);
    logic [31:0] lfsr_d;
    logic [31:0] lfsr_q;

    // Next LFSR value: load has priority over step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == 32'h0000_0000) ? DEFAULT_SEED : seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign sym = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/pattern_game_ctrl.sv
// Pattern-memory game controller: grows a random symbol pattern one step
// per round, plays it to the display and checks user entries in classic
// or reverse order, with an entry timeout and a round score.
module pattern_game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_SYMBOLS = 4,
    parameter int MAX_LEN     = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SYM_W       = $clog2(NUM_SYMBOLS),
    parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    pattern_game_ctrl_if.master bus
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYC > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    state_e           state_d, state_q;
    mode_e            mode_d, mode_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] idx_d, idx_q;
    logic [LEN_W-1:0] score_d, score_q;
    logic [TMO_W-1:0] tmo_d, tmo_q;
    logic [SYM_W-1:0] mem_d [MAX_LEN];
    logic [SYM_W-1:0] mem_q [MAX_LEN];
    logic             play_valid_d, play_valid_q;
    logic [SYM_W-1:0] play_sym_d, play_sym_q;
    logic             in_ready_d, in_ready_q;
    logic             busy_d, busy_q;
    logic             game_over_d, game_over_q;
    logic             win_d, win_q;

    logic             lfsr_load_s;
    logic             lfsr_step_s;
    logic [SYM_W-1:0] lfsr_sym_s;
    logic             play_hs_s;
    logic             accept_s;
    logic [LEN_W-1:0] len_m1_s;
    logic             last_pos_s;

    pattern_lfsr #(.OUT_W(SYM_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_s),
        .step  (lfsr_step_s),
        .seed  (bus.seed),
        .sym   (lfsr_sym_s)
    );

    assign play_hs_s  = play_valid_q & bus.play_ready;
    assign accept_s   = bus.in_valid & in_ready_q;
    assign len_m1_s   = len_q - LEN_W'(1);
    assign last_pos_s = (mode_q == MODE_CLASSIC) ? (idx_q == len_m1_s) : (idx_q == LEN_W'(0));

    // Next-state, datapath updates and next registered outputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        idx_d       = idx_q;
        score_d     = score_q;
        tmo_d       = tmo_q;
        mem_d       = mem_q;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;

        case (state_q)
            IDLE, FAIL, WIN: begin
                if (bus.start) begin
                    mode_d      = mode_e'(bus.mode);
                    lfsr_load_s = 1'b1;
                    len_d       = LEN_W'(0);
                    score_d     = LEN_W'(0);
                    state_d     = EXTEND;
                end else begin
                    state_d = state_q;
                end
            end
            EXTEND: begin
                mem_d[len_q[ADDR_W-1:0]] = lfsr_sym_s;
                len_d       = len_q + LEN_W'(1);
                lfsr_step_s = 1'b1;
                idx_d       = LEN_W'(0);
                state_d     = PLAY;
            end
            PLAY: begin
                if (play_hs_s) begin
                    if (idx_q == len_m1_s) begin
                        state_d = COLLECT;
                        idx_d   = (mode_q == MODE_CLASSIC) ? LEN_W'(0) : len_m1_s;
                        tmo_d   = TMO_W'(0);
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            COLLECT: begin
                // An entry on the expiry cycle takes precedence over the timeout.
                if (accept_s) begin
                    tmo_d = TMO_W'(0);
                    if (bus.in_sym != mem_q[idx_q[ADDR_W-1:0]]) begin
                        state_d = FAIL;
                    end else if (last_pos_s) begin
                        state_d = ROUND_OK;
                    end else if (mode_q == MODE_CLASSIC) begin
                        idx_d = idx_q + LEN_W'(1);
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = FAIL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ROUND_OK: begin
                score_d = score_q + LEN_W'(1);
                if (len_q == LEN_MAX) begin
                    state_d = WIN;
                end else begin
                    state_d = EXTEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state; play_sym reads the
        // updated memory so the symbol written in EXTEND is shown at once.
        play_valid_d = (state_d == PLAY);
        if (state_d == PLAY) begin
            play_sym_d = mem_d[idx_d[ADDR_W-1:0]];
        end else begin
            play_sym_d = {SYM_W{1'b0}};
        end
        in_ready_d  = (state_d == COLLECT);
        busy_d      = !((state_d == IDLE) || (state_d == FAIL) || (state_d == WIN));
        game_over_d = (state_d == FAIL);
        win_d       = (state_d == WIN);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= MODE_CLASSIC;
            len_q        <= LEN_W'(0);
            idx_q        <= LEN_W'(0);
            score_q      <= LEN_W'(0);
            tmo_q        <= TMO_W'(0);
            play_valid_q <= 1'b0;
            play_sym_q   <= {SYM_W{1'b0}};
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            score_q      <= score_d;
            tmo_q        <= tmo_d;
            play_valid_q <= play_valid_d;
            play_sym_q   <= play_sym_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
        end
    end

    // Pattern storage; never cleared, len bounds every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.play_valid = play_valid_q;
    assign bus.play_sym   = play_sym_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.score      = score_q;
    assign bus.busy       = busy_q;
    assign bus.game_over  = game_over_q;
    assign bus.win        = win_q;
endmodule
